div_40_16: RTL and testbench

DIV_40_16 -- requirements
Module: div_40_16

---
 rtl/div_40_16_pkg.sv | 41 ++++
 rtl/div_40_16_stage.sv | 33 +++
 rtl/div_40_16.sv | 98 +++++++++
 tb/tb_div_40_16.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_40_16_pkg.sv
// Shared widths, output field offsets and per-stage state for the 40/16 unsigned divider.
package div_40_16_pkg;

  localparam int unsigned DIVIDEND_W = 40;
  localparam int unsigned DIVISOR_W  = 16;
  localparam int unsigned DOUT_W     = 56;

  localparam int unsigned QUO_LSB = 16;
  localparam int unsigned QUO_MSB = 55;
  localparam int unsigned REM_LSB = 0;
  localparam int unsigned REM_MSB = 15;

  // dvd holds the dividend bits not yet consumed, MSB first.
  typedef struct packed {
    logic                  valid;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVIDEND_W-1:0] quo;
    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W-1:0]  divisor;
  } stage_t;

  localparam int unsigned STAGE_W = $bits(stage_t);

  // Iterations done by stage idx: ceil(40/latency) each, trailing stages take what is left.
  function automatic int unsigned stage_iters(int unsigned latency, int unsigned idx);
    int unsigned per_stage;
    int unsigned done;
    int unsigned result;
    per_stage = (DIVIDEND_W + latency - 1) / latency;
    done      = idx * per_stage;
    if (done >= DIVIDEND_W) begin
      result = 0;
    end else if (DIVIDEND_W - done < per_stage) begin
      result = DIVIDEND_W - done;
    end else begin
      result = per_stage;
    end
    return result;
  endfunction

endpackage

// File: rtl/div_40_16_stage.sv
// One combinational slice of restoring long division: STAGE_ITERS quotient bits per pass.
module div_40_16_stage
  import div_40_16_pkg::*;
#(
  parameter int unsigned STAGE_ITERS = 5
) (
  input  logic [STAGE_W-1:0] i_state,
  output logic [STAGE_W-1:0] o_state
);

  stage_t               w_state;
  logic [DIVISOR_W:0]   w_trial;

  always_comb begin
    w_state = i_state;
    w_trial = '0;
    for (int unsigned j = 0; j < STAGE_ITERS; j++) begin
      w_trial     = {w_state.rem, w_state.dvd[DIVIDEND_W-1]};
      w_state.dvd = w_state.dvd << 1;
      // A zero divisor always "fits", giving all-ones quotient and dividend[15:0] as remainder.
      if (w_trial >= {1'b0, w_state.divisor}) begin
        w_state.rem = w_trial[DIVISOR_W-1:0] - w_state.divisor;
        w_state.quo = {w_state.quo[DIVIDEND_W-2:0], 1'b1};
      end else begin
        w_state.rem = w_trial[DIVISOR_W-1:0];
        w_state.quo = {w_state.quo[DIVIDEND_W-2:0], 1'b0};
      end
    end
  end

  assign o_state = w_state;

endmodule

// File: rtl/div_40_16.sv
// Fully pipelined 40/16 unsigned divider, result LATENCY cycles after operand acceptance.
// Define DIV_40_16_REMAINDER_EN to drive the remainder onto dout[15:0]; otherwise those bits are 0.
module div_40_16
  import div_40_16_pkg::*;
#(
  parameter int unsigned LATENCY = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_divisor_tvalid,
  input  logic [DIVISOR_W-1:0]  s_axis_divisor_tdata,
  input  logic                  s_axis_dividend_tvalid,
  input  logic [DIVIDEND_W-1:0] s_axis_dividend_tdata,
  output logic                  m_axis_dout_tvalid,
  output logic [DOUT_W-1:0]     m_axis_dout_tdata
);

  logic                  r_opnd_valid;
  logic [DIVIDEND_W-1:0] r_opnd_dvd;
  logic [DIVISOR_W-1:0]  r_opnd_dvs;

  stage_t w_stage_in  [LATENCY];
  stage_t w_stage_out [LATENCY];
  stage_t w_last;

  logic [DOUT_W-1:0] w_dout;
  logic              w_unused_last;

  logic              r_dout_valid;
  logic [DOUT_W-1:0] r_dout_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opnd_valid <= 1'b0;
    end else begin
      r_opnd_valid <= s_axis_divisor_tvalid & s_axis_dividend_tvalid;
    end
    r_opnd_dvd <= s_axis_dividend_tdata;
    r_opnd_dvs <= s_axis_divisor_tdata;
  end

  assign w_stage_in[0] = '{valid:   r_opnd_valid,
                           rem:     '0,
                           quo:     '0,
                           dvd:     r_opnd_dvd,
                           divisor: r_opnd_dvs};

  // The last stage feeds the output register directly, so only LATENCY-1 stage registers exist.
  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    div_40_16_stage #(
      .STAGE_ITERS(stage_iters(LATENCY, i))
    ) u_stage (
      .i_state(w_stage_in[i]),
      .o_state(w_stage_out[i])
    );

    if (i < LATENCY - 1) begin : g_reg
      stage_t r_state;

      always_ff @(posedge clk) begin
        r_state <= w_stage_out[i];
        if (rst) begin
          r_state.valid <= 1'b0;
        end
      end

      assign w_stage_in[i+1] = r_state;
    end
  end

  assign w_last = w_stage_out[LATENCY-1];

  assign w_dout[QUO_MSB:QUO_LSB] = w_last.quo;
`ifdef DIV_40_16_REMAINDER_EN
  assign w_dout[REM_MSB:REM_LSB] = w_last.rem;
  assign w_unused_last = ^{w_last.dvd, w_last.divisor};
`else
  assign w_dout[REM_MSB:REM_LSB] = '0;
  assign w_unused_last = ^{w_last.dvd, w_last.divisor, w_last.rem};
`endif

  // Data only moves on a valid result so the bus holds steady between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_valid <= 1'b0;
      r_dout_data  <= '0;
    end else begin
      r_dout_valid <= w_last.valid;
      if (w_last.valid) begin
        r_dout_data <= w_dout;
      end
    end
  end

  assign m_axis_dout_tvalid = r_dout_valid;
  assign m_axis_dout_tdata  = r_dout_data;

endmodule

// File: tb/tb_div_40_16.sv
// Self-checking bench for div_40_16: directed table, random burst, valid gating and reset flush.
module tb_div_40_16;

  localparam int unsigned LATENCY = 8;
`ifdef DIV_40_16_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        dvs_v;
  logic [15:0] dvs;
  logic        dvd_v;
  logic [39:0] dvd;
  logic        out_v;
  logic [55:0] out_d;

  div_40_16 #(
    .LATENCY(LATENCY)
  ) u_dut (
    .clk                   (clk),
    .rst                   (rst),
    .s_axis_divisor_tvalid (dvs_v),
    .s_axis_divisor_tdata  (dvs),
    .s_axis_dividend_tvalid(dvd_v),
    .s_axis_dividend_tdata (dvd),
    .m_axis_dout_tvalid    (out_v),
    .m_axis_dout_tdata     (out_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks  = 0;
  int n_errors  = 0;
  int edge_no   = 0;
  int pulse_cnt = 0;
  bit mon_en    = 1'b0;

  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct {
    logic [55:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [55:0] last_data;

  typedef struct {
    logic [39:0] dd;
    logic [15:0] dv;
    logic [39:0] q;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  function automatic logic [55:0] model(input logic [39:0] a, input logic [15:0] b);
    logic [39:0] q;
    logic [15:0] r;
    if (b == 16'd0) begin
      q = '1;
      r = a[15:0];
    end else begin
      q = a / {24'd0, b};
      r = 16'(a % {24'd0, b});
    end
    return {q, REM_EN ? r : 16'h0};
  endfunction

  task automatic drive(input bit a_dvs_v, input bit a_dvd_v, input logic [39:0] a_dvd,
                       input logic [15:0] a_dvs, input bit a_rst);
    @(posedge clk);
    #1;
    dvs_v = a_dvs_v;
    dvd_v = a_dvd_v;
    dvd   = a_dvd;
    dvs   = a_dvs;
    rst   = a_rst;
  endtask

  task automatic wait_valid(output int seen, output bit ok);
    ok   = 1'b0;
    seen = -1;
    for (int i = 0; i < int'(LATENCY) + 10 && !ok; i++) begin
      @(negedge clk);
      if (out_v === 1'b1) begin
        seen = edge_no;
        ok   = 1'b1;
      end
    end
  endtask

  function automatic logic [15:0] rand_dvs();
    if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 15));
    return 16'($urandom);
  endfunction

  function automatic logic [39:0] rand_dvd();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // Scoreboard: every accepted pair must emerge exactly LATENCY edges later, in order.
  initial begin
    last_data = '0;
    forever begin
      @(negedge clk);
      if (out_v === 1'b1) pulse_cnt++;
      if (mon_en) begin
        if (exp_q.size() > 0 && exp_q[0].due == edge_no) begin
          check("out_valid", 64'(out_v), 64'd1);
          check("out_data", 64'(out_d), 64'(exp_q[0].data));
          last_data = exp_q[0].data;
          void'(exp_q.pop_front());
        end else begin
          check("idle_valid", 64'(out_v), 64'd0);
          check("hold_data", 64'(out_d), 64'(last_data));
        end
        if (rst) begin
          exp_q.delete();
          last_data = '0;
        end else if (dvs_v && dvd_v) begin
          exp_q.push_back('{data: model(dvd, dvs), due: edge_no + 1 + int'(LATENCY)});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc;
    int          seen;
    bit          ok;
    int          base;
    logic [39:0] pd;
    logic [15:0] pv;

    rst   = 1'b1;
    dvs_v = 1'b0;
    dvd_v = 1'b0;
    dvs   = '0;
    dvd   = '0;

    vecs[0] = '{40'h80_0000_007F, 16'd128,    40'h01_0000_0000, 16'd127};
    vecs[1] = '{40'h01_0000_0002, 16'd3,      40'h00_5555_5556, 16'd0};
    vecs[2] = '{40'h12_3456_789A, 16'd0,      40'hFF_FFFF_FFFF, 16'h789A};
    vecs[3] = '{40'hFF_FFFF_FFFF, 16'hFFFF,   40'h00_0100_0100, 16'h00FF};
    vecs[4] = '{40'd100,          16'd7,      40'd14,           16'd2};
    vecs[5] = '{40'd0,            16'd5,      40'd0,            16'd0};
    vecs[6] = '{40'h00_0000_FFFF, 16'd1,      40'h00_0000_FFFF, 16'd0};
    vecs[7] = '{40'hFF_FFFF_FFFF, 16'd1,      40'hFF_FFFF_FFFF, 16'd0};

    repeat (3) drive(1'b0, 1'b0, '0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("reset_valid", 64'(out_v), 64'd0);
    check("reset_data", 64'(out_d), 64'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, vecs[i].dd, vecs[i].dv, 1'b0);
      acc = edge_no + 1;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      wait_valid(seen, ok);
      check("vec_seen", 64'(ok), 64'd1);
      check("vec_latency", 64'(seen - acc), 64'(LATENCY));
      check("vec_quo", 64'(out_d[55:16]), 64'(vecs[i].q));
      check("vec_rem", 64'(out_d[15:0]), 64'(REM_EN ? vecs[i].r : 16'h0));
    end

    base = pulse_cnt;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b1, rand_dvd(), rand_dvs(), 1'b0);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (LATENCY + 3) @(negedge clk);
    check("burst_pulses", 64'(pulse_cnt - base), 64'd200);
    check("burst_drained", 64'(exp_q.size()), 64'd0);

    base = pulse_cnt;
    repeat (5) drive(1'b0, 1'b1, rand_dvd(), rand_dvs(), 1'b0);
    repeat (3) drive(1'b1, 1'b0, rand_dvd(), rand_dvs(), 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (LATENCY + 3) @(negedge clk);
    check("one_valid_pulses", 64'(pulse_cnt - base), 64'd0);

    base = pulse_cnt;
    repeat (4) drive(1'b1, 1'b1, rand_dvd(), rand_dvs(), 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b1, rand_dvd(), rand_dvs(), 1'b1);
    pd = rand_dvd();
    pv = 16'($urandom_range(1, 65535));
    drive(1'b1, 1'b1, pd, pv, 1'b0);
    acc = edge_no + 1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    wait_valid(seen, ok);
    check("post_rst_seen", 64'(ok), 64'd1);
    check("post_rst_latency", 64'(seen - acc), 64'(LATENCY));
    check("post_rst_data", 64'(out_d), 64'(model(pd, pv)));
    repeat (3) @(negedge clk);
    check("flush_pulses", 64'(pulse_cnt - base), 64'd1);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
